data_memory_sized: RTL and testbench

- Parametrised successor to the single-cycle word data memory of the MIPS-style datapath; sits between the ALU result (address) and the write-back mux.
- Adds byte/halfword/word accesses with sign or zero extension, little-endian lanes, alignment and range fault detection, and a configurable access latency behind a request/ready handshake, so the control unit can stall on memory.
- Memory array contents are never touched by reset.

---
 rtl/data_memory_sized.sv | 103 ++++++++++
 tb/tb_data_memory_sized.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/data_memory_sized.sv
// data_memory_sized: byte/half/word data memory with fault detection and configurable latency handshake
module data_memory_sized #(
   parameter int DEPTH      = 256,
   parameter int LATENCY    = 1,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  MemRead,
   input  logic                  MemWrite,
   input  logic [ADDR_WIDTH-1:0] ALUOut,
   input  logic [31:0]           reg2data,
   input  logic [1:0]            mem_size,
   input  logic                  mem_signed,
   output logic [31:0]           memout,
   output logic                  mem_ready,
   output logic                  mem_fault,
   output logic                  mem_busy
);
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
   localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH+1)'(4 * DEPTH);
   state_t state, state_nx;
   logic [31:0] mem [DEPTH];
   logic [3:0] cnt;
   logic rd_q, wr_q, sgn_q, flt_q;
   logic [1:0] size_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [31:0] wdata_q;
   logic accept, commit, flt_in;
   logic [IW-1:0] idx;
   logic [31:0] rword, wword, rdata;
   logic [7:0] rbyte;
   logic [15:0] rhalf;
   logic [3:0] be;

   assign mem_busy = state != IDLE;

   // Next state: accept in IDLE, count down in WAIT, single RESP cycle
   always_comb begin
      accept   = state == IDLE && (MemRead || MemWrite);
      commit   = state == WAIT && cnt == 4'd0;
      state_nx = accept ? WAIT : commit ? RESP : state == WAIT ? WAIT : IDLE;
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else state <= state_nx;
   end

   // Fault evaluation on the live request, latched at acceptance
   always_comb begin
      flt_in = (MemRead && MemWrite) || mem_size == 2'd3 ||
               (mem_size == 2'd1 && ALUOut[0]) ||
               (mem_size == 2'd2 && ALUOut[1:0] != 2'd0) ||
               ({1'b0, ALUOut} >= LIMIT);
   end

   // Lane selection, extension and store-data replication from latched request
   always_comb begin
      idx   = addr_q[IW+1:2];
      rword = mem[idx];
      rbyte = rword[8*addr_q[1:0] +: 8];
      rhalf = addr_q[1] ? rword[31:16] : rword[15:0];
      rdata = size_q == 2'd0 ? {{24{sgn_q & rbyte[7]}}, rbyte} :
              size_q == 2'd1 ? {{16{sgn_q & rhalf[15]}}, rhalf} : rword;
      be    = size_q == 2'd0 ? 4'b0001 << addr_q[1:0] :
              size_q == 2'd1 ? (addr_q[1] ? 4'b1100 : 4'b0011) : 4'b1111;
      wword = size_q == 2'd0 ? {4{wdata_q[7:0]}} :
              size_q == 2'd1 ? {2{wdata_q[15:0]}} : wdata_q;
   end

   // Request capture, latency counter and registered response
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt       <= 4'd0;
         memout    <= 32'd0;
         mem_ready <= 1'b0;
         mem_fault <= 1'b0;
      end else begin
         if (accept) begin
            rd_q    <= MemRead;
            wr_q    <= MemWrite;
            addr_q  <= ALUOut;
            wdata_q <= reg2data;
            size_q  <= mem_size;
            sgn_q   <= mem_signed;
            flt_q   <= flt_in;
            cnt     <= 4'(LATENCY - 1);
         end else if (state == WAIT && cnt != 4'd0) cnt <= cnt - 4'd1;
         mem_ready <= commit;
         mem_fault <= commit && flt_q;
         if (commit && (flt_q || rd_q)) memout <= flt_q ? 32'd0 : rdata;
      end
   end

   // Array write of the selected lanes; reset blocks the commit and never clears contents
   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++)
         if (!reset && commit && wr_q && !flt_q && be[i]) mem[idx][8*i +: 8] <= wword[8*i +: 8];
   end
endmodule

// File: tb/tb_data_memory_sized.sv
// tb_data_memory_sized: directed checks of sized accesses, faults, latency, reset abort and back-to-back
module tb_data_memory_sized;
   logic clk = 1'b0, reset = 1'b1;
   logic rd1 = 1'b0, wr1 = 1'b0, rd4 = 1'b0, wr4 = 1'b0;
   logic [31:0] addr = '0, wdata = '0;
   logic [1:0] size = '0;
   logic sgn = 1'b0;
   logic [31:0] memout1, memout4;
   logic ready1, ready4, fault1, fault4, busy1, busy4;
   int vectors = 0, miscompares = 0;
   logic [31:0] out;
   logic flt, after;
   int lat;

   always #5 clk = ~clk;

   data_memory_sized #(.DEPTH(256), .LATENCY(1), .ADDR_WIDTH(32)) u1 (
      .clk(clk), .reset(reset), .MemRead(rd1), .MemWrite(wr1), .ALUOut(addr), .reg2data(wdata),
      .mem_size(size), .mem_signed(sgn), .memout(memout1), .mem_ready(ready1), .mem_fault(fault1), .mem_busy(busy1));

   data_memory_sized #(.DEPTH(256), .LATENCY(4), .ADDR_WIDTH(32)) u4 (
      .clk(clk), .reset(reset), .MemRead(rd4), .MemWrite(wr4), .ALUOut(addr), .reg2data(wdata),
      .mem_size(size), .mem_signed(sgn), .memout(memout4), .mem_ready(ready4), .mem_fault(fault4), .mem_busy(busy4));

   task automatic access(input bit d4, input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] dat,
                         input logic [1:0] sz, input bit sg);
      @(negedge clk);
      addr = a; wdata = dat; size = sz; sgn = sg;
      if (d4) begin rd4 = rd; wr4 = wr; end else begin rd1 = rd; wr1 = wr; end
      lat = -1;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (i == 1) begin addr = ~a; wdata = ~dat; size = ~sz; sgn = ~sg; end
         if (d4 ? ready4 : ready1) begin lat = i; break; end
      end
      rd1 = 0; wr1 = 0; rd4 = 0; wr4 = 0;
      out = d4 ? memout4 : memout1;
      flt = d4 ? fault4 : fault1;
      @(negedge clk);
      after = d4 ? ready4 : ready1;
   endtask

   task automatic test_reset;
      repeat (3) @(negedge clk);
      vectors++; if ({memout1, ready1, fault1, busy1} !== 35'd0) begin miscompares++; $display("FAIL reset_l1: got %h %b%b%b want 0 000", memout1, ready1, fault1, busy1); end
      vectors++; if ({memout4, ready4, fault4, busy4} !== 35'd0) begin miscompares++; $display("FAIL reset_l4: got %h %b%b%b want 0 000", memout4, ready4, fault4, busy4); end
      reset = 1'b0;
   endtask

   task automatic test_word;
      access(0, 0, 1, 32, 32'hF0F0F0F0, 2, 0);
      vectors++; if (lat !== 2) begin miscompares++; $display("FAIL sw_latency: got %0d want 2", lat); end
      vectors++; if (after !== 1'b0) begin miscompares++; $display("FAIL sw_pulse_width: ready after pulse %b want 0", after); end
      vectors++; if (flt !== 1'b0) begin miscompares++; $display("FAIL sw_fault: got %b want 0", flt); end
      access(0, 1, 0, 32, 0, 2, 1);
      vectors++; if (lat !== 2) begin miscompares++; $display("FAIL lw_latency: got %0d want 2", lat); end
      vectors++; if (out !== 32'hF0F0F0F0 || flt !== 1'b0) begin miscompares++; $display("FAIL lw_data: got %h/%b want f0f0f0f0/0", out, flt); end
      access(0, 0, 1, 36, 32'h12345678, 2, 0);
      vectors++; if (out !== 32'hF0F0F0F0) begin miscompares++; $display("FAIL sw_keeps_memout: got %h want f0f0f0f0", out); end
   endtask

   task automatic test_byte;
      access(0, 0, 1, 32, 32'h0, 2, 0);
      access(0, 0, 1, 33, 32'hAAAAAA85, 0, 0);
      access(0, 1, 0, 32, 0, 2, 0);
      vectors++; if (out !== 32'h00008500) begin miscompares++; $display("FAIL sb_merge: got %h want 00008500", out); end
      access(0, 1, 0, 33, 0, 0, 1);
      vectors++; if (out !== 32'hFFFFFF85) begin miscompares++; $display("FAIL lb_signed: got %h want ffffff85", out); end
      access(0, 1, 0, 33, 0, 0, 0);
      vectors++; if (out !== 32'h00000085) begin miscompares++; $display("FAIL lbu: got %h want 00000085", out); end
      access(0, 1, 0, 32, 0, 0, 1);
      vectors++; if (out !== 32'h00000000) begin miscompares++; $display("FAIL lb_lane0: got %h want 00000000", out); end
   endtask

   task automatic test_half;
      access(0, 0, 1, 40, 32'h11223344, 2, 0);
      access(0, 0, 1, 42, 32'h5555BEEF, 1, 0);
      access(0, 1, 0, 42, 0, 1, 1);
      vectors++; if (out !== 32'hFFFFBEEF) begin miscompares++; $display("FAIL lh_signed: got %h want ffffbeef", out); end
      access(0, 1, 0, 42, 0, 1, 0);
      vectors++; if (out !== 32'h0000BEEF) begin miscompares++; $display("FAIL lhu: got %h want 0000beef", out); end
      access(0, 1, 0, 40, 0, 2, 0);
      vectors++; if (out !== 32'hBEEF3344) begin miscompares++; $display("FAIL sh_merge: got %h want beef3344", out); end
      access(0, 1, 0, 40, 0, 1, 1);
      vectors++; if (out !== 32'h00003344) begin miscompares++; $display("FAIL lh_low_positive: got %h want 00003344", out); end
   endtask

   task automatic test_faults;
      access(0, 0, 1, 0, 32'h01020304, 2, 0);
      access(0, 1, 0, 6, 0, 2, 0);
      vectors++; if (flt !== 1'b1 || out !== 32'h0) begin miscompares++; $display("FAIL lw_misaligned: got %b/%h want 1/0", flt, out); end
      access(0, 1, 0, 0, 0, 2, 0);
      vectors++; if (out !== 32'h01020304 || flt !== 1'b0) begin miscompares++; $display("FAIL lw_word0: got %h/%b want 01020304/0", out, flt); end
      access(0, 0, 1, 3, 32'hFFFF, 1, 0);
      vectors++; if (flt !== 1'b1 || out !== 32'h0) begin miscompares++; $display("FAIL sh_misaligned: got %b/%h want 1/0", flt, out); end
      access(0, 1, 0, 1024, 0, 2, 0);
      vectors++; if (flt !== 1'b1) begin miscompares++; $display("FAIL lw_range: got %b want 1", flt); end
      access(0, 1, 0, 32'h80000020, 0, 0, 0);
      vectors++; if (flt !== 1'b1) begin miscompares++; $display("FAIL lb_high_addr: got %b want 1", flt); end
      access(0, 1, 0, 1023, 0, 0, 0);
      vectors++; if (flt !== 1'b0) begin miscompares++; $display("FAIL lb_last_byte: got %b want 0", flt); end
      access(0, 1, 0, 0, 0, 3, 0);
      vectors++; if (flt !== 1'b1) begin miscompares++; $display("FAIL size3: got %b want 1", flt); end
      access(0, 1, 1, 0, 32'hDEADBEEF, 2, 0);
      vectors++; if (flt !== 1'b1 || out !== 32'h0) begin miscompares++; $display("FAIL rd_wr_both: got %b/%h want 1/0", flt, out); end
      access(0, 1, 0, 0, 0, 2, 0);
      vectors++; if (out !== 32'h01020304) begin miscompares++; $display("FAIL faults_no_write: got %h want 01020304", out); end
   endtask

   task automatic test_reset_abort;
      access(1, 0, 1, 40, 32'h77, 2, 0);
      vectors++; if (lat !== 5) begin miscompares++; $display("FAIL l4_latency: got %0d want 5", lat); end
      access(1, 1, 0, 40, 0, 2, 0);
      vectors++; if (out !== 32'h77) begin miscompares++; $display("FAIL l4_lw: got %h want 00000077", out); end
      @(negedge clk);
      addr = 40; wdata = 5; size = 2; wr4 = 1;
      @(negedge clk);
      @(negedge clk);
      vectors++; if (busy4 !== 1'b1) begin miscompares++; $display("FAIL l4_busy: got %b want 1", busy4); end
      reset = 1; wr4 = 0;
      @(negedge clk);
      vectors++; if ({memout4, ready4, fault4, busy4} !== 35'd0) begin miscompares++; $display("FAIL abort_outputs: got %h %b%b%b want 0 000", memout4, ready4, fault4, busy4); end
      reset = 0;
      access(1, 1, 0, 40, 0, 2, 0);
      vectors++; if (out !== 32'h77 || lat !== 5) begin miscompares++; $display("FAIL abort_dropped: got %h lat %0d want 00000077 lat 5", out, lat); end
   endtask

   task automatic test_back_to_back;
      int pulses, idle, first, last, prev;
      bit gap_bad, data_bad;
      pulses = 0; idle = 0; first = 0; last = 0; prev = 0; gap_bad = 0; data_bad = 0;
      @(negedge clk);
      addr = 0; size = 2; sgn = 0; rd1 = 1;
      for (int c = 1; c <= 30 && pulses < 3; c++) begin
         @(negedge clk);
         if (pulses > 0 && !busy1) idle++;
         if (ready1) begin
            if (pulses > 0 && c - prev != 3) gap_bad = 1;
            if (memout1 !== 32'h01020304) data_bad = 1;
            if (pulses == 0) first = c;
            prev = c; last = c; pulses++;
         end
      end
      rd1 = 0;
      @(negedge clk);
      vectors++; if (pulses !== 3) begin miscompares++; $display("FAIL b2b_pulses: got %0d want 3", pulses); end
      vectors++; if (gap_bad || last - first !== 6) begin miscompares++; $display("FAIL b2b_spacing: got span %0d want 6", last - first); end
      vectors++; if (idle !== 2) begin miscompares++; $display("FAIL b2b_idle: got %0d idle cycles want 2", idle); end
      vectors++; if (data_bad) begin miscompares++; $display("FAIL b2b_data: got bad memout want 01020304"); end
   endtask

   initial begin
      test_reset;
      test_word;
      test_byte;
      test_half;
      test_faults;
      test_reset_abort;
      test_back_to_back;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
